// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: start/PC control, instruction memory read port, execute-stage handshake.
// master = fetch unit side, slave = PC / memory / execute-stage side.
// No logic here, only the signal grouping.
interface instr_fetch_unit_if;
   logic        start;
   logic [15:0] pc_addr;
   logic        pc_done;
   logic        pc_en;
   logic [15:0] pc_load_addr;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic        mem_rvalid;
   logic [15:0] mem_rdata;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        halted;

   modport master (
      input  start, pc_addr, mem_rvalid, mem_rdata, instr_ready,
      output pc_done, pc_en, pc_load_addr, mem_rd, mem_addr, instr, instr_valid, halted
   );

   modport slave (
      output start, pc_addr, mem_rvalid, mem_rdata, instr_ready,
      input  pc_done, pc_en, pc_load_addr, mem_rd, mem_addr, instr, instr_valid, halted
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch FSM: reads memory at PC, hands words to execute, steps/rewinds PC, stops on HALT.
// Latency: read strobe to next read is 4 cycles after mem_rvalid when instr_ready is held high.
// Backpressure: instr/instr_valid held stable in HOLD until instr_ready; FETCH_LOOP_EN adds LOOP_BEGIN/LOOP_END.
module instr_fetch_unit (
   input  logic               clk,
   input  logic               rst,
   instr_fetch_unit_if.master bus
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, STEP, REWIND, HALTED} state_t;

   localparam logic [3:0] OP_HALT = 4'hF;
`ifdef FETCH_LOOP_EN
   localparam logic [3:0] OP_LOOP_BEGIN = 4'hE;
   localparam logic [3:0] OP_LOOP_END   = 4'hD;
`endif

   state_t      state_q, state_d;
   logic        mem_rd_q, mem_rd_d;
   logic        pc_done_q, pc_done_d;
   logic [15:0] instr_q, instr_d;
   logic        instr_valid_q, instr_valid_d;
   logic        halted_q, halted_d;
   logic [3:0]  opcode;
`ifdef FETCH_LOOP_EN
   logic        pc_en_q, pc_en_d;
   logic [15:0] loop_addr_q, loop_addr_d;
   logic [11:0] loop_cnt_q, loop_cnt_d;
`endif

   assign opcode = bus.mem_rdata[15:12];

   // Next-state and next-output logic; pulse outputs are set on entry to the state that owns them.
   always_comb begin
      state_d       = state_q;
      mem_rd_d      = 1'b0;
      pc_done_d     = 1'b0;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      halted_d      = halted_q;
`ifdef FETCH_LOOP_EN
      pc_en_d       = 1'b0;
      loop_addr_d   = loop_addr_q;
      loop_cnt_d    = loop_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d  = REQ;
               mem_rd_d = 1'b1;
            end
         end
         REQ: state_d = WAIT;
         WAIT: begin
            // Read data is only looked at here; a late response in any other state is dropped.
            if (bus.mem_rvalid) begin
               if (opcode == OP_HALT) begin
                  state_d  = HALTED;
                  halted_d = 1'b1;
               end
`ifdef FETCH_LOOP_EN
               else if (opcode == OP_LOOP_BEGIN) begin
                  // Body starts right after the LOOP_BEGIN word; a zero count still runs once.
                  loop_addr_d = bus.pc_addr + 16'd1;
                  loop_cnt_d  = (bus.mem_rdata[11:0] == 12'd0) ? 12'd1 : bus.mem_rdata[11:0];
                  state_d     = STEP;
                  pc_done_d   = 1'b1;
               end else if (opcode == OP_LOOP_END) begin
                  if (loop_cnt_q > 12'd1) begin
                     loop_cnt_d = loop_cnt_q - 12'd1;
                     state_d    = REWIND;
                     pc_en_d    = 1'b1;
                  end else begin
                     // Last pass, or a stray LOOP_END with no loop open: fall through.
                     loop_cnt_d = 12'd0;
                     state_d    = STEP;
                     pc_done_d  = 1'b1;
                  end
               end
`endif
               else begin
                  state_d       = HOLD;
                  instr_d       = bus.mem_rdata;
                  instr_valid_d = 1'b1;
               end
            end
         end
         HOLD: begin
            if (bus.instr_ready) begin
               state_d       = STEP;
               instr_valid_d = 1'b0;
               pc_done_d     = 1'b1;
            end
         end
         STEP, REWIND: begin
            state_d  = REQ;
            mem_rd_d = 1'b1;
         end
         HALTED: state_d = HALTED;
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; reset abandons any fetch in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         mem_rd_q      <= 1'b0;
         pc_done_q     <= 1'b0;
         instr_q       <= 16'h0000;
         instr_valid_q <= 1'b0;
         halted_q      <= 1'b0;
`ifdef FETCH_LOOP_EN
         pc_en_q       <= 1'b0;
         loop_addr_q   <= 16'h0000;
         loop_cnt_q    <= 12'd0;
`endif
      end else begin
         state_q       <= state_d;
         mem_rd_q      <= mem_rd_d;
         pc_done_q     <= pc_done_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         halted_q      <= halted_d;
`ifdef FETCH_LOOP_EN
         pc_en_q       <= pc_en_d;
         loop_addr_q   <= loop_addr_d;
         loop_cnt_q    <= loop_cnt_d;
`endif
      end
   end

   // PC only changes on the pc_done/pc_en edges, so the read address follows it directly during REQ.
   assign bus.mem_rd      = mem_rd_q;
   assign bus.mem_addr    = mem_rd_q ? bus.pc_addr : 16'h0000;
   assign bus.pc_done     = pc_done_q;
   assign bus.instr       = instr_q;
   assign bus.instr_valid = instr_valid_q;
   assign bus.halted      = halted_q;
`ifdef FETCH_LOOP_EN
   assign bus.pc_en        = pc_en_q;
   assign bus.pc_load_addr = loop_addr_q;
`else
   assign bus.pc_en        = 1'b0;
   assign bus.pc_load_addr = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed fetch/stall/reset cases plus random programs
// run against an instruction-level interpreter of the fetch rules.
// Works with and without FETCH_LOOP_EN; the interpreter follows the same macro.
module tb_instr_fetch_unit;

   logic clk;
   logic rst;
   instr_fetch_unit_if bus ();

   instr_fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_err    = 0;

   logic [15:0] mem [0:65535];
   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];
   logic [15:0] addr_q[$];
   logic [15:0] tgt_q[$];
   int          exp_done, exp_en;
   int          done_cnt, en_cnt;
   int          rsp_wait, lat_max, ready_pct;
   logic [15:0] rsp_addr, prev_instr;
   logic        prev_stall;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] plain_word();
      logic [3:0] op;
      op = 4'($urandom_range(0, 12));
      return {op, 12'($urandom)};
   endfunction

   // Instruction-level interpreter: walks the program as an ISA would and records
   // the fetch addresses, delivered words, rewind targets and PC steps.
   task automatic build_expect(input logic [15:0] base);
      logic [15:0] pc, w;
      logic [15:0] la;
      int          lc;
      exp_q.delete(); addr_q.delete(); tgt_q.delete();
      exp_done = 0;
      pc = base; la = 16'h0000; lc = 0;
      for (int n = 0; n < 4000; n++) begin
         w = mem[pc];
         addr_q.push_back(pc);
         if (w[15:12] == 4'hF) break;
`ifdef FETCH_LOOP_EN
         if (w[15:12] == 4'hE) begin
            la = pc + 16'd1;
            lc = (w[11:0] == 12'd0) ? 1 : int'(w[11:0]);
            pc = pc + 16'd1; exp_done++;
            continue;
         end
         if (w[15:12] == 4'hD) begin
            if (lc > 1) begin
               lc = lc - 1; tgt_q.push_back(la); pc = la;
            end else begin
               lc = 0; pc = pc + 16'd1; exp_done++;
            end
            continue;
         end
`endif
         exp_q.push_back(w);
         pc = pc + 16'd1; exp_done++;
      end
      exp_en = tgt_q.size();
   endtask

   task automatic gen_prog(input logic [15:0] base, input int nseg);
      logic [15:0] a;
      a = base;
      for (int s = 0; s < nseg; s++) begin
         int r, nb;
         r = $urandom_range(0, 9);
         if (r <= 5) begin
            mem[a] = plain_word(); a++;
         end else if (r <= 8) begin
            mem[a] = {4'hE, 12'($urandom_range(0, 3))}; a++;
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
               mem[a] = plain_word(); a++;
            end
            mem[a] = {4'hD, 12'($urandom)}; a++;
         end else begin
            mem[a] = {4'hD, 12'($urandom)}; a++;
         end
      end
      mem[a] = {4'hF, 12'($urandom)};
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.start = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.instr_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One cycle of the PC register, memory and execute stage seen by the DUT.
   task automatic env_cycle();
      @(negedge clk);
      chk("pc_done_pc_en_excl", 32'(bus.pc_done & bus.pc_en), 32'd0);
      if (bus.pc_done) begin
         done_cnt++;
         bus.pc_addr = bus.pc_addr + 16'd1;
      end
      if (bus.pc_en) begin
         en_cnt++;
         chk("rewind_expected", 32'(tgt_q.size() > 0), 32'd1);
         if (tgt_q.size() > 0) chk("rewind_target", 32'(bus.pc_load_addr), 32'(tgt_q.pop_front()));
         bus.pc_addr = bus.pc_load_addr;
      end
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 16'($urandom);
      if (rsp_wait > 0) begin
         rsp_wait--;
         if (rsp_wait == 0) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = mem[rsp_addr];
         end
      end
      if (bus.mem_rd) begin
         chk("fetch_expected", 32'(addr_q.size() > 0), 32'd1);
         if (addr_q.size() > 0) chk("fetch_addr", 32'(bus.mem_addr), 32'(addr_q.pop_front()));
         rsp_addr = bus.mem_addr;
         rsp_wait = $urandom_range(1, lat_max);
      end
      if (prev_stall) begin
         chk("hold_instr", 32'(bus.instr), 32'(prev_instr));
         chk("hold_valid", 32'(bus.instr_valid), 32'd1);
      end
      bus.instr_ready = ($urandom_range(0, 99) < ready_pct);
      if (bus.instr_valid && bus.instr_ready) got_q.push_back(bus.instr);
      prev_stall = bus.instr_valid && !bus.instr_ready;
      prev_instr = bus.instr;
   endtask

   task automatic run_prog(input logic [15:0] base, input int lat, input int rdy);
      int n, rd;
      build_expect(base);
      do_reset();
      lat_max = lat; ready_pct = rdy;
      got_q.delete();
      done_cnt = 0; en_cnt = 0; rsp_wait = 0; prev_stall = 1'b0;
      bus.pc_addr = base;
      bus.start = 1'b1;
      env_cycle();
      bus.start = 1'b0;
      n = 0;
      while (!bus.halted && n < 3000) begin
         env_cycle();
         n++;
      end
      chk("halt_reached", 32'(bus.halted), 32'd1);
      chk("deliver_count", 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         chk("deliver_word", 32'(got_q[i]), 32'(exp_q[i]));
      chk("pc_done_count", 32'(done_cnt), 32'(exp_done));
      chk("pc_en_count", 32'(en_cnt), 32'(exp_en));
      chk("fetches_left", 32'(addr_q.size()), 32'd0);
      // HALTED is sticky even with start held high.
      bus.start = 1'b1;
      rd = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.mem_rd) rd++;
      end
      chk("halt_no_rd", 32'(rd), 32'd0);
      chk("halt_sticky", 32'(bus.halted), 32'd1);
      do_reset();
      chk("rst_clears_halt", 32'(bus.halted), 32'd0);
      @(negedge clk);
      chk("idle_after_rst", 32'(bus.mem_rd), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0;
      bus.pc_addr = 16'h0000;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata = 16'h0000;
      bus.instr_ready = 1'b0;
      lat_max = 1; ready_pct = 100; rsp_wait = 0; prev_stall = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_pc_done", 32'(bus.pc_done), 32'd0);
      chk("rst_pc_en", 32'(bus.pc_en), 32'd0);
      chk("rst_pc_load_addr", 32'(bus.pc_load_addr), 32'd0);
      chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_instr", 32'(bus.instr), 32'd0);
      chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
      chk("rst_halted", 32'(bus.halted), 32'd0);
      rst = 1'b0;

      // Basic fetch, five-cycle stall in HOLD, then step to the next address.
      bus.pc_addr = 16'h0000;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("d_mem_rd", 32'(bus.mem_rd), 32'd1);
      chk("d_mem_addr", 32'(bus.mem_addr), 32'h0000);
      @(negedge clk);
      chk("d_wait_no_rd", 32'(bus.mem_rd), 32'd0);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata = 16'h1234;
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("d_hold_instr", 32'(bus.instr), 32'h1234);
         chk("d_hold_valid", 32'(bus.instr_valid), 32'd1);
         chk("d_hold_no_done", 32'(bus.pc_done), 32'd0);
         chk("d_hold_no_rd", 32'(bus.mem_rd), 32'd0);
         @(negedge clk);
      end
      bus.instr_ready = 1'b1;
      @(negedge clk);
      bus.instr_ready = 1'b0;
      chk("d_step_done", 32'(bus.pc_done), 32'd1);
      chk("d_step_valid_low", 32'(bus.instr_valid), 32'd0);
      bus.pc_addr = 16'h0001;
      @(negedge clk);
      chk("d_next_rd", 32'(bus.mem_rd), 32'd1);
      chk("d_next_addr", 32'(bus.mem_addr), 32'h0001);
      chk("d_single_done", 32'(bus.pc_done), 32'd0);

      // Reset while waiting for read data; the late response must be ignored.
      do_reset();
      bus.pc_addr = 16'h0040;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("r_mem_rd", 32'(bus.mem_rd), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata = 16'h5555;
      repeat (2) @(negedge clk);
      bus.mem_rvalid = 1'b0;
      repeat (3) @(negedge clk);
      chk("r_instr_valid", 32'(bus.instr_valid), 32'd0);
      chk("r_instr", 32'(bus.instr), 32'h0000);
      chk("r_no_rd", 32'(bus.mem_rd), 32'd0);

      // Loop program: three passes of the body with the loop feature, plain words without it.
      mem[16'h0010] = 16'hE003;
      mem[16'h0011] = 16'h2000;
      mem[16'h0012] = 16'hD000;
      mem[16'h0013] = 16'hF000;
      run_prog(16'h0010, 1, 100);
`ifdef FETCH_LOOP_EN
      chk("loop_body_count", 32'(got_q.size()), 32'd3);
      chk("loop_pc_en_count", 32'(en_cnt), 32'd2);
`else
      chk("noloop_first_word", 32'(got_q.size() > 0 ? got_q[0] : 16'h0000), 32'hE003);
      chk("noloop_pc_en_count", 32'(en_cnt), 32'd0);
`endif

      // LOOP_BEGIN at the top of memory: loop target wraps to 0x0000.
      mem[16'hFFFF] = 16'hE002;
      mem[16'h0000] = 16'h1111;
      mem[16'h0001] = 16'hD000;
      mem[16'h0002] = 16'hF000;
      run_prog(16'hFFFF, 2, 50);

      for (int t = 0; t < 24; t++) begin
         logic [15:0] base;
         base = 16'($urandom);
         gen_prog(base, $urandom_range(3, 12));
         run_prog(base, 1 + (t % 3), (t % 4 == 0) ? 100 : 30 + 10 * (t % 4));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The module SHALL use reset rst, asynchronous, active-high, and clock clk; all state SHALL be updated on posedge clk.
REQ-002 Ports SHALL be as listed:
- clk  in  1  system clock
- rst  in  1  async active-high reset
- start  in  1  leave IDLE and begin fetching
- pc_addr  in  16  current program counter value
- pc_done  out  1  one-cycle pulse: PC += 1
- pc_en  out  1  one-cycle pulse: PC loads pc_load_addr
- pc_load_addr  out  16  rewind target for PC
- mem_rd  out  1  one-cycle instruction memory read strobe
- mem_addr  out  16  read address, valid while mem_rd=1
- mem_rvalid  in  1  read data valid
- mem_rdata  in  16  read data
- instr  out  16  instruction to execute stage
- instr_valid  out  1  instr holds a valid instruction
- instr_ready  in  1  execute stage accepts instr
- halted  out  1  HALT instruction reached

Function
REQ-003 FSM states SHALL be IDLE, REQ, WAIT, HOLD, STEP, REWIND, HALTED.
REQ-004 IDLE: start=1 -> REQ; otherwise stay.
REQ-005 REQ: mem_rd=1 and mem_addr=pc_addr for exactly one cycle -> WAIT.
REQ-006 WAIT: mem_rvalid sampled only in this state; on mem_rvalid=1, mem_rdata SHALL be captured and decoded on opcode [15:12]. mem_rvalid in any other state SHALL be ignored.
REQ-007 Opcode 4'hF (HALT) -> HALTED; halted=1; no pc_done. HALTED SHALL be left only by rst.
REQ-008 Ordinary opcode -> HOLD, instr=captured word, instr_valid=1.
REQ-009 HOLD: instr and instr_valid SHALL stay stable until instr_ready=1; on handshake -> STEP and instr_valid=0 next cycle.
REQ-010 STEP: pc_done=1 for one cycle -> REQ. The next read uses the incremented pc_addr.
REQ-011 REWIND: pc_en=1 for one cycle, pc_load_addr=loop_addr -> REQ.
REQ-012 pc_done and pc_en SHALL never be high in the same cycle.
REQ-013 Minimum fetch-to-next-fetch latency for an ordinary instruction SHALL be 4 cycles after mem_rvalid with instr_ready held 1 (WAIT capture, HOLD, STEP, REQ).
REQ-014 Opcode 4'hE (LOOP_BEGIN): loop_addr<=pc_addr+1 (16-bit wrap, 0xFFFF+1=0x0000); loop_cnt<=[11:0], with 0 treated as 1; -> STEP; not forwarded to instr.
REQ-015 Opcode 4'hD (LOOP_END):
- loop_cnt>1: loop_cnt-=1 -> REWIND
- loop_cnt<=1: loop_cnt<=0 -> STEP
- not forwarded to instr.
REQ-016 Loops SHALL be single-level. A LOOP_BEGIN while loop_cnt!=0 SHALL overwrite loop_addr and loop_cnt.
REQ-017 A LOOP_END with loop_cnt=0 SHALL act as a no-op (-> STEP).

Reset
REQ-018 On rst, the following SHALL all be 0 and the state SHALL be IDLE: pc_done, pc_en, pc_load_addr, mem_rd, mem_addr, instr, instr_valid, halted, loop_addr, loop_cnt.
REQ-019 Reset asserted mid-fetch SHALL abandon the fetch. A later mem_rvalid SHALL have no effect.

Configuration
REQ-020 Macro FETCH_LOOP_EN defined: REQ-014..REQ-017 SHALL apply.
REQ-021 FETCH_LOOP_EN undefined:
- no loop_addr or loop_cnt registers
- pc_en tied 0 and pc_load_addr tied 0
- opcodes 4'hE and 4'hD SHALL be forwarded as ordinary instructions per REQ-008.

Verification
REQ-022 Reset, start=1, pc_addr=0x0000, mem_rdata=0x1234 one cycle after mem_rd -> instr=0x1234, instr_valid=1; after instr_ready, one pc_done pulse, then mem_rd with mem_addr=0x0001.
REQ-023 instr_ready=0 for 5 cycles in HOLD -> instr stable at 0x1234, no pc_done, no mem_rd; handshake on cycle 6 -> pc_done next cycle.
REQ-024 (FETCH_LOOP_EN) pc_addr=0x0010 fetches 0xE003, body 0x2000 at 0x0011, LOOP_END 0xD000 at 0x0012 -> 0x2000 delivered 3 times; 2 pc_en pulses with pc_load_addr=0x0011; then pc_done past 0x0012.
REQ-025 0xF000 fetched -> halted=1, no further mem_rd for 20 cycles despite start=1; rst -> halted=0, IDLE.
REQ-026 rst during WAIT, then mem_rvalid=1 with 0x5555 -> instr_valid stays 0 and instr stays 0x0000.
REQ-027 (FETCH_LOOP_EN undefined) 0xE003 fetched -> instr=0xE003, instr_valid=1, pc_en never asserted.
